// File: rtl/wtg_bpred.sv
// wtg_bpred: next-PC unit with a direct-mapped BTB and saturating-counter BHT, plus EX-stage resolution.
// Defining WTG_BPRED_STATS_EN adds the stat_branches_o / stat_mispred_o event counters.
`ifndef WTG_OP_BIT
`define WTG_OP_BIT 4
`endif

module wtg_bpred #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int PC_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_W-1:0]        if_pc_i,
    output logic [PC_W-1:0]        pred_pc_o,
    output logic                   pred_taken_o,
    input  logic                   ex_valid_i,
    input  logic [`WTG_OP_BIT-1:0] ex_op_i,
    input  logic [PC_W-1:0]        ex_pc_i,
    input  logic [PC_W-1:0]        ex_off32_i,
    input  logic [25:0]            ex_imm26_i,
    input  logic [PC_W-1:0]        ex_data_x_i,
    input  logic [PC_W-1:0]        ex_data_y_i,
    input  logic [PC_W-1:0]        ex_pred_pc_i,
    output logic                   redirect_o,
    output logic [PC_W-1:0]        redirect_pc_o,
    output logic                   branched_o,
    output logic                   jumped_o,
    output logic                   is_branch_o
`ifdef WTG_BPRED_STATS_EN
    ,
    output logic [31:0]            stat_branches_o,
    output logic [31:0]            stat_mispred_o
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(2 ** (CNT_W - 1) - 1);

    localparam logic [`WTG_OP_BIT-1:0] OP_J32  = `WTG_OP_BIT'(1);
    localparam logic [`WTG_OP_BIT-1:0] OP_J26  = `WTG_OP_BIT'(2);
    localparam logic [`WTG_OP_BIT-1:0] OP_BEQ  = `WTG_OP_BIT'(3);
    localparam logic [`WTG_OP_BIT-1:0] OP_BNE  = `WTG_OP_BIT'(4);
    localparam logic [`WTG_OP_BIT-1:0] OP_BLEZ = `WTG_OP_BIT'(5);
    localparam logic [`WTG_OP_BIT-1:0] OP_BGTZ = `WTG_OP_BIT'(6);
    localparam logic [`WTG_OP_BIT-1:0] OP_BLTZ = `WTG_OP_BIT'(7);
    localparam logic [`WTG_OP_BIT-1:0] OP_BGEZ = `WTG_OP_BIT'(8);

    logic [ENTRIES-1:0] valid_q;
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic               jflag_q  [ENTRIES];

    // ---------------- fetch lookup ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx        = if_pc_i[IDX_W+1:2];
    assign f_tag        = if_pc_i[PC_W-1:IDX_W+2];
    assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken_o = f_hit && (cnt_q[f_idx][CNT_W-1] || jflag_q[f_idx]);
    assign pred_pc_o    = pred_taken_o ? target_q[f_idx] : if_pc_i + PC_W'(4);

    // ---------------- EX resolution ----------------
    logic [PC_W-1:0] pc_4;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] actual_pc;
    logic            taken;
    logic            is_branch;
    logic            jumped;

    always_comb begin
        pc_4      = ex_pc_i + PC_W'(4);
        target    = pc_4 + (ex_off32_i << 2);
        taken     = 1'b0;
        is_branch = 1'b0;
        jumped    = 1'b0;
        unique case (ex_op_i)
            OP_J32:  begin jumped = 1'b1; taken = 1'b1; target = ex_data_x_i; end
            OP_J26:  begin
                jumped = 1'b1;
                taken  = 1'b1;
                target = {pc_4[PC_W-1:28], ex_imm26_i, 2'b00};
            end
            OP_BEQ:  begin is_branch = 1'b1; taken = (ex_data_x_i == ex_data_y_i); end
            OP_BNE:  begin is_branch = 1'b1; taken = (ex_data_x_i != ex_data_y_i); end
            OP_BLEZ: begin is_branch = 1'b1; taken = ($signed(ex_data_x_i) <= 0); end
            OP_BGTZ: begin is_branch = 1'b1; taken = ($signed(ex_data_x_i) >  0); end
            OP_BLTZ: begin is_branch = 1'b1; taken = ex_data_x_i[PC_W-1]; end
            OP_BGEZ: begin is_branch = 1'b1; taken = !ex_data_x_i[PC_W-1]; end
            default: ;
        endcase
        actual_pc = taken ? target : pc_4;
    end

    assign redirect_o    = ex_valid_i && (actual_pc != ex_pred_pc_i);
    assign redirect_pc_o = actual_pc;
    assign branched_o    = is_branch && taken;
    assign jumped_o      = jumped;
    assign is_branch_o   = is_branch;

    // ---------------- training ----------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [CNT_W-1:0] u_cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_wr;
    logic             entry_wr;
    logic             jflag_d;

    assign u_idx = ex_pc_i[IDX_W+1:2];
    assign u_tag = ex_pc_i[PC_W-1:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_cnt = cnt_q[u_idx];

    // A taken allocate into a missing or aliased slot restarts at weakly-taken.
    always_comb begin
        cnt_d    = u_cnt;
        cnt_wr   = 1'b0;
        entry_wr = 1'b0;
        jflag_d  = 1'b0;
        if (ex_valid_i) begin
            if (is_branch) begin
                if (taken) begin
                    entry_wr = 1'b1;
                    cnt_wr   = 1'b1;
                    if (!u_hit)              cnt_d = CNT_WT;
                    else if (u_cnt != CNT_MAX) cnt_d = u_cnt + CNT_W'(1);
                end else if (u_hit) begin
                    cnt_wr = 1'b1;
                    if (u_cnt != '0) cnt_d = u_cnt - CNT_W'(1);
                end
            end else if (ex_op_i == OP_J26) begin
                entry_wr = 1'b1;
                jflag_d  = 1'b1;
                cnt_wr   = 1'b1;
                cnt_d    = CNT_MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
        end else begin
            if (entry_wr) valid_q[u_idx] <= 1'b1;
            if (cnt_wr)   cnt_q[u_idx]   <= cnt_d;
        end
    end

    // NOTE: tag/target/jflag arrays carry no reset; the valid bit gates every use of them.
    always_ff @(posedge clk) begin
        if (entry_wr) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= actual_pc;
            jflag_q[u_idx]  <= jflag_d;
        end
    end

`ifdef WTG_BPRED_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispred_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (ex_valid_i && (is_branch || jumped)) stat_branches_q <= stat_branches_q + 32'd1;
            if (redirect_o)                          stat_mispred_q  <= stat_mispred_q + 32'd1;
        end
    end

    assign stat_branches_o = stat_branches_q;
    assign stat_mispred_o  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_wtg_bpred.sv
// tb_wtg_bpred: directed + randomized checks of wtg_bpred against a table-level reference model.
// Stats outputs are checked when WTG_BPRED_STATS_EN is defined.
module tb_wtg_bpred;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 2;
    localparam int PC_W    = 32;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int CNT_WT  = 1 << (CNT_W - 1);

    localparam logic [3:0] OP_NONE = 4'd0, OP_J32 = 4'd1, OP_J26 = 4'd2, OP_BEQ = 4'd3,
                           OP_BNE = 4'd4, OP_BLEZ = 4'd5, OP_BGTZ = 4'd6, OP_BLTZ = 4'd7,
                           OP_BGEZ = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, pred_pc, ex_pc, ex_off32, ex_data_x, ex_data_y, ex_pred_pc, redirect_pc;
    logic        pred_taken, ex_valid, redirect, branched, jumped, is_branch;
    logic [3:0]  ex_op;
    logic [25:0] ex_imm26;
`ifdef WTG_BPRED_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    wtg_bpred #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_pc_i      (if_pc),
        .pred_pc_o    (pred_pc),
        .pred_taken_o (pred_taken),
        .ex_valid_i   (ex_valid),
        .ex_op_i      (ex_op),
        .ex_pc_i      (ex_pc),
        .ex_off32_i   (ex_off32),
        .ex_imm26_i   (ex_imm26),
        .ex_data_x_i  (ex_data_x),
        .ex_data_y_i  (ex_data_y),
        .ex_pred_pc_i (ex_pred_pc),
        .redirect_o   (redirect),
        .redirect_pc_o(redirect_pc),
        .branched_o   (branched),
        .jumped_o     (jumped),
        .is_branch_o  (is_branch)
`ifdef WTG_BPRED_STATS_EN
        ,
        .stat_branches_o(stat_branches),
        .stat_mispred_o (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    bit          m_jflag  [ENTRIES];
    int unsigned m_br, m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (ENTRIES * 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = CNT_WT - 1;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output logic [31:0] ppc, output bit ptk);
        int i = idx_of(pc);
        bit hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        ptk = hit && (m_cnt[i] >= CNT_WT || m_jflag[i]);
        ppc = ptk ? m_target[i] : pc + 4;
    endtask

    task automatic resolve(output logic [31:0] actual, output bit tk, output bit isb, output bit jmp);
        int sx = $signed(ex_data_x);
        logic [31:0] pc4 = ex_pc + 4;
        tk = 0; isb = 0; jmp = 0;
        actual = pc4;
        case (ex_op)
            OP_J32:  begin jmp = 1; tk = 1; actual = ex_data_x; end
            OP_J26:  begin jmp = 1; tk = 1; actual = (pc4 & 32'hF000_0000) + {4'b0, ex_imm26, 2'b00}; end
            OP_BEQ:  begin isb = 1; tk = (ex_data_x == ex_data_y); end
            OP_BNE:  begin isb = 1; tk = (ex_data_x != ex_data_y); end
            OP_BLEZ: begin isb = 1; tk = (sx <= 0); end
            OP_BGTZ: begin isb = 1; tk = (sx > 0); end
            OP_BLTZ: begin isb = 1; tk = (sx < 0); end
            OP_BGEZ: begin isb = 1; tk = (sx >= 0); end
            default: ;
        endcase
        if (isb && tk) actual = pc4 + ex_off32 * 4;
    endtask

    // Compare all outputs against the model; then apply this cycle's training if the edge will.
    task automatic model_check(input bit do_update);
        logic [31:0] ppc, actual;
        bit ptk, tk, isb, jmp, exp_redir, present;
        int i;
        model_pred(if_pc, ppc, ptk);
        resolve(actual, tk, isb, jmp);
        exp_redir = ex_valid && (actual != ex_pred_pc);
        check("pred_pc", pred_pc, ppc);
        check("pred_taken", 32'(pred_taken), 32'(ptk));
        check("redirect", 32'(redirect), 32'(exp_redir));
        check("redirect_pc", redirect_pc, actual);
        check("branched", 32'(branched), 32'(isb && tk));
        check("jumped", 32'(jumped), 32'(jmp));
        check("is_branch", 32'(is_branch), 32'(isb));
        if (do_update && ex_valid) begin
            i = idx_of(ex_pc);
            present = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
            if (isb || jmp) m_br++;
            if (exp_redir) m_mis++;
            if (isb && tk) begin
                m_cnt[i] = !present ? CNT_WT : (m_cnt[i] < CNT_MAX ? m_cnt[i] + 1 : CNT_MAX);
                m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_target[i] = actual; m_jflag[i] = 0;
            end else if (isb && present) begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end else if (ex_op == OP_J26) begin
                m_cnt[i] = CNT_MAX;
                m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_target[i] = actual; m_jflag[i] = 1;
            end
        end
    endtask

    task automatic drive(input logic [31:0] ipc, input bit v, input logic [3:0] op,
                         input logic [31:0] pc, input logic [31:0] off, input logic [25:0] imm,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] pp);
        @(negedge clk);
        if_pc = ipc; ex_valid = v; ex_op = op; ex_pc = pc; ex_off32 = off;
        ex_imm26 = imm; ex_data_x = x; ex_data_y = y; ex_pred_pc = pp;
        #1;
    endtask

    function automatic logic [31:0] pool_pc();
        return 32'h0040_0000 + ($urandom_range(0, 47) << 2);
    endfunction

    // Expected pred_taken for the BEQ at 0x00400010 after each training edge.
    bit          seq_tk   [7] = '{1, 1, 1, 0, 0, 0, 0};
    bit          seq_take [7] = '{1, 0, 0, 0, 0, 1, 0};

    initial begin
        logic [31:0] ppc, pc, x;
        bit ptk;

        rst = 1'b1;
        if_pc = 32'h0040_0000; ex_valid = 0; ex_op = OP_NONE; ex_pc = 0; ex_off32 = 0;
        ex_imm26 = 0; ex_data_x = 0; ex_data_y = 0; ex_pred_pc = 0;
        model_reset();
        #2;
        check("rst_pred_pc", pred_pc, 32'h0040_0004);
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        model_check(0);
        @(negedge clk);
        rst = 1'b0;

        // Taken BEQ with a fall-through prediction redirects at once.
        drive(32'h0040_0000, 1, OP_BEQ, 32'h0040_0010, 32'd4, 0, 32'd5, 32'd5, 32'h0040_0014);
        check("beq_redirect", 32'(redirect), 32'd1);
        check("beq_redirect_pc", redirect_pc, 32'h0040_0024);
        check("beq_branched", 32'(branched), 32'd1);
        model_check(1);

        // Counter walk: taken, NT x4 (saturate at 0), taken.
        for (int k = 0; k < 7; k++) begin
            model_pred(32'h0040_0010, ppc, ptk);
            drive(32'h0040_0010, k < 6, OP_BEQ, 32'h0040_0010, 32'd4, 0, 32'd5,
                  seq_take[k] ? 32'd5 : 32'd6, ppc);
            check("train_pred_taken", 32'(pred_taken), 32'(seq_tk[k]));
            if (k == 0) check("train_pred_pc", pred_pc, 32'h0040_0024);
            model_check(1);
        end

        // J26 installs a jflag entry; the next fetch of it predicts the jump.
        drive(32'h0040_0000, 1, OP_J26, 32'h1000_0008, 0, 26'h100, 0, 0, 32'h1000_000C);
        check("j26_redirect_pc", redirect_pc, 32'h1000_0400);
        check("j26_jumped", 32'(jumped), 32'd1);
        model_check(1);
        drive(32'h1000_0008, 1, OP_J26, 32'h1000_0008, 0, 26'h100, 0, 0, 32'h1000_0400);
        check("j26_pred_pc", pred_pc, 32'h1000_0400);
        check("j26_no_redirect", 32'(redirect), 32'd0);
        model_check(1);

        // Zero/sign boundaries of the single-operand branches.
        drive(32'h0040_0000, 1, OP_BGEZ, 32'h0040_0100, 32'd2, 0, 32'd0, 0, 32'h0040_0104);
        check("bgez_zero", 32'(branched), 32'd1);
        model_check(1);
        drive(32'h0040_0000, 1, OP_BLTZ, 32'h0040_0120, 32'd2, 0, 32'hFFFF_FFFF, 0, 32'h0040_0124);
        check("bltz_m1", 32'(branched), 32'd1);
        model_check(1);
        drive(32'h0040_0000, 1, OP_BLEZ, 32'h0040_0140, 32'd2, 0, 32'd1, 0, 32'h0040_014C);
        check("blez_one_redirect", 32'(redirect), 32'd1);
        check("blez_one_pc", redirect_pc, 32'h0040_0144);
        model_check(1);

        // Aliasing: 0x00400040 evicts 0x00400000 from slot 0.
        drive(32'h0040_0000, 1, OP_BEQ, 32'h0040_0000, 32'd8, 0, 1, 1, 32'h0040_0004);
        model_check(1);
        drive(32'h0040_0000, 1, OP_BEQ, 32'h0040_0040, 32'd8, 0, 1, 1, 32'h0040_0044);
        model_check(1);
        drive(32'h0040_0000, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
        check("alias_pred_pc", pred_pc, 32'h0040_0004);
        model_check(1);

        // Reset mid-operation: tables clear immediately, resolution still works.
        drive(32'h0040_0040, 1, OP_BEQ, 32'h0040_0040, 32'd8, 0, 1, 1, 32'h0040_0044);
        check("pre_rst_pred_taken", 32'(pred_taken), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_pred_taken", 32'(pred_taken), 32'd0);
        check("mid_rst_redirect", 32'(redirect), 32'd1);
        model_check(0);
        @(negedge clk);
        ex_valid = 0;
        rst = 1'b0;

        // Randomized traffic over a small aliasing PC pool.
        for (int n = 0; n < 800; n++) begin
            pc = pool_pc();
            x  = ($urandom_range(0, 7) == 0) ? pool_pc() : 32'($urandom_range(0, 4)) - 32'd2;
            if ($urandom_range(0, 9) < 6) model_pred(pc, ppc, ptk);
            else if ($urandom_range(0, 1) == 0) ppc = pc + 4;
            else ppc = pool_pc();
            drive($urandom_range(0, 1) ? pc : pool_pc(), $urandom_range(0, 7) != 0,
                  4'($urandom_range(0, 10)), pc, 32'($urandom_range(0, 16)) - 32'd8,
                  26'($urandom_range(0, 255)), x, 32'($urandom_range(0, 4)) - 32'd2, ppc);
            model_check(1);
        end

        drive(32'h0040_0000, 0, OP_NONE, 0, 0, 0, 0, 0, 0);
        model_check(1);
`ifdef WTG_BPRED_STATS_EN
        check("stat_branches", stat_branches, m_br);
        check("stat_mispred", stat_mispred, m_mis);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wtg_bpred.md
Name: wtg_bpred

Overview:
- Parametrised next-PC unit with branch prediction.
- Fetch side: direct-mapped BTB plus saturating-counter BHT supplies a predicted next PC each cycle.
- EX side: resolves J32/J26/BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ.
  - Compares the real target with the prediction carried down the pipe.
  - Raises a redirect on mismatch.
  - Trains the tables on the next clock edge.
- Replaces the purely combinational where-to-go logic between IF and EX.

Parameters:
- ENTRIES, 16, BTB/BHT depth; power of two, 2..256; IDX_W = log2(ENTRIES).
- CNT_W, 2, saturating counter width, 1..4; taken when MSB = 1.
- PC_W, 32, PC/data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  PC_W  PC being fetched.
- pred_pc  out  PC_W  predicted next PC.
- pred_taken  out  1  prediction is a taken redirect.
- ex_valid  in  1  EX-stage instruction valid (not bubble/flushed).
- ex_op  in  `WTG_OP_BIT  op from Core.vh; NONE/J32/J26/BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ.
- ex_pc  in  PC_W  PC of the EX instruction.
- ex_off32  in  PC_W  sign-extended branch offset, in words.
- ex_imm26  in  26  jump index.
- ex_data_x  in  PC_W  rs value, signed.
- ex_data_y  in  PC_W  rt value, signed.
- ex_pred_pc  in  PC_W  pred_pc captured at fetch of this instruction.
- redirect  out  1  mispredict; fetch must restart at redirect_pc.
- redirect_pc  out  PC_W  correct next PC.
- branched  out  1  conditional branch resolved taken.
- jumped  out  1  J32 or J26.
- is_branch  out  1  op is conditional.

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous, active-high.
  - On reset: all valid bits 0; all counters = 2^(CNT_W-1)-1 (weakly not-taken).
- Address split: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- Fetch lookup (combinational from registered state):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && (cnt MSB || jflag).
  - pred_pc = pred_taken ? target[idx] : if_pc+4.
  - With no valid entries, pred_pc = if_pc+4 and pred_taken = 0.
- Resolution (combinational), with pc_4 = ex_pc+4:
  - J26 target = {pc_4[31:28], imm26, 2'b00}.
  - B target = pc_4 + (off32<<2).
  - J32 target = data_x.
  - Conditions, signed compare: BEQ x==y; BNE x!=y; BLEZ x<=0; BGTZ x>0; BLTZ x<0; BGEZ x>=0.
  - actual_pc = taken ? target : pc_4.
  - NONE/unknown op: actual_pc = pc_4; branched = jumped = is_branch = 0.
- Redirect:
  - redirect = ex_valid && (actual_pc != ex_pred_pc); redirect_pc = actual_pc.
  - When ex_valid = 0: redirect = 0, and flags still decode ex_op.
- Update, at the rising edge when ex_valid is set:
  - Conditional op:
    - Counter saturates +1 if taken, -1 if not; no wrap past 0 or 2^CNT_W-1.
    - If taken: write tag, target, valid=1, jflag=0.
    - If not taken and entry missing: no allocation.
    - If not taken and entry present: only the counter moves.
  - J26: write tag, target, valid, jflag=1; counter forced to max.
  - J32 and NONE: no table write; J32 is always predicted via pc_4 unless aliased.
  - Tag mismatch on allocate: entry overwritten; counter reset to weakly-taken 2^(CNT_W-1).
- Simultaneous fetch lookup and update to the same idx: lookup sees the pre-edge value (no bypass).
- Reset asserted mid-operation:
  - Tables clear immediately (asynchronous).
  - redirect is then decided only by resolution against ex_pred_pc.
- Latency:
  - Prediction: 0 cycles.
  - redirect: 0 cycles after EX inputs.
  - Training: visible to lookup 1 cycle after the update edge.

Optional Feature:
- Macro: WTG_BPRED_STATS_EN.
- When defined, add outputs stat_branches [31:0] and stat_mispred [31:0].
  - Reset to 0.
  - stat_branches: +1 per ex_valid cycle with is_branch or jumped.
  - stat_mispred: +1 per redirect cycle.
  - Both wrap modulo 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is unchanged.

Test Plan:
- Reset, then if_pc=0x00400000 → pred_pc=0x00400004, pred_taken=0.
- BEQ at 0x00400010, off32=4, x=y=5, ex_pred_pc=0x00400014:
  - Redirect immediately: redirect=1, redirect_pc=0x00400024, branched=1.
  - Following cycle, if_pc=0x00400010 → pred_pc=0x00400024.
- Same BEQ taken twice, then not-taken three times (CNT_W=2):
  - Counter steps 01→10→11→10→01→00.
  - pred_taken after each edge: 1, 1, 1, 0, 0.
  - Counter stays 00 on a fourth not-taken.
- J26 at 0x10000008, imm26=0x0000100:
  - actual_pc=0x10000400; entry installed with jflag.
  - Next lookup at that PC predicts 0x10000400 and gives no redirect.
- BGEZ x=0 and BLTZ x=-1 → both taken. BLEZ x=1 → not taken, redirect_pc=pc+4 when predicted taken.
- Aliasing (ENTRIES=16):
  - Train 0x00400000, then train 0x00400040 (same idx).
  - Lookup of 0x00400000 → miss, pred_pc=0x00400004.
  - With WTG_BPRED_STATS_EN defined: stat_branches and stat_mispred values match the count of injected events.
